// File: rtl/ibex_md_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Imported by the sequencer and its testbench.
package ibex_md_seq_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } md_seq_state_e;

  parameter logic [31:0] MD_DIV0_QUOT = 32'hFFFFFFFF;
  parameter logic [31:0] MD_OVF_QUOT  = 32'h80000000;

endpackage

// File: rtl/ibex_md_seq.sv
// Iterative MUL/MULH/DIV/REM sequencer: 32 shift-add or restoring-divide steps on
// operand magnitudes, one sign fix-up cycle, then a held response.
module ibex_md_seq
  import ibex_md_seq_pkg::*;
#(
  parameter  int Width = 32,
  localparam int CntW  = $clog2(Width)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       md_op_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             kill_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [Width-1:0] result_o,
  output logic             busy_o
);

  function automatic logic [Width-1:0] mag(input logic [Width-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  md_seq_state_e    state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  md_op_e           op_q;
  logic             neg_a_q, neg_b_q;
  logic [Width-1:0] hi_q, lo_q, opnd_q;
  logic [Width-1:0] result_q;

  // Request decode: effective operand signs and the two early-exit divide cases.
  md_op_e           op_in;
  logic             is_div_in, div_signed_in, sa_in, sb_in;
  logic             div_zero, div_ovf, fast_path, accept;
  logic [Width-1:0] fast_result;

  assign op_in         = md_op_e'(md_op_i);
  assign is_div_in     = (op_in == MD_OP_DIV) || (op_in == MD_OP_REM);
  assign div_signed_in = (signed_mode_i == 2'b11);
  assign sa_in = op_a_i[Width-1] & (is_div_in ? div_signed_in : signed_mode_i[0]);
  assign sb_in = op_b_i[Width-1] & (is_div_in ? div_signed_in : signed_mode_i[1]);
  assign div_zero  = is_div_in && (op_b_i == '0);
  assign div_ovf   = is_div_in && div_signed_in && (op_a_i == MD_OVF_QUOT) && (op_b_i == '1);
  assign fast_path = div_zero || div_ovf;
  assign fast_result = div_zero ? ((op_in == MD_OP_DIV) ? MD_DIV0_QUOT : op_a_i)
                                : ((op_in == MD_OP_DIV) ? MD_OVF_QUOT  : '0);
  assign accept    = req_valid_i & req_ready_o;

  // Shared iteration datapath. Multiply keeps {hi,lo} as the accumulator with the
  // multiplier shifting out of lo; divide shifts the dividend out of lo into hi
  // while quotient bits shift into lo.
  logic             is_mul_q;
  logic [Width:0]   mul_sum, div_shift;
  logic [Width-1:0] div_sub;
  logic             div_ge;
  logic [Width-1:0] hi_d, lo_d;

  assign is_mul_q  = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[Width-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  // When div_ge holds the difference fits in Width bits, so the wrapped subtract is exact.
  assign div_sub   = div_shift[Width-1:0] - opnd_q;

  always_comb begin
    if (is_mul_q) begin
      hi_d = mul_sum[Width:1];
      lo_d = {mul_sum[0], lo_q[Width-1:1]};
    end else begin
      hi_d = div_ge ? div_sub : div_shift[Width-1:0];
      lo_d = {lo_q[Width-2:0], div_ge};
    end
  end

  // Sign fix-up and result selection.
  logic [2*Width-1:0] prod, prod_s;
  logic [Width-1:0]   fix_result;

  assign prod   = {hi_q, lo_q};
  assign prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;

  always_comb begin
    // NOTE: every path assigns fix_result, so this block cannot infer a latch.
    fix_result = '0;
    unique case (op_q)
      MD_OP_MULL: fix_result = prod_s[Width-1:0];
      MD_OP_MULH: fix_result = prod_s[2*Width-1:Width];
      MD_OP_DIV:  fix_result = mag(lo_q, neg_a_q ^ neg_b_q);
      MD_OP_REM:  fix_result = mag(hi_q, neg_a_q);
      default:    fix_result = '0;
    endcase
  end

  // State register, counter and result register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CntW'(Width - 1);
      end else if (state_q == MD_CALC) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (accept && fast_path) begin
        result_q <= fast_result;
      end else if (state_q == MD_FIX) begin
        result_q <= fix_result;
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q    <= op_in;
      neg_a_q <= sa_in;
      neg_b_q <= sb_in;
      hi_q    <= '0;
      opnd_q  <= is_div_in ? mag(op_b_i, sb_in) : mag(op_a_i, sa_in);
      lo_q    <= is_div_in ? mag(op_a_i, sa_in) : mag(op_b_i, sb_in);
    end else if (state_q == MD_CALC) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (accept) state_d = fast_path ? MD_DONE : MD_CALC;
      MD_CALC: if (cnt_q == '0) state_d = MD_FIX;
      MD_FIX:  state_d = MD_DONE;
      MD_DONE: if (resp_ready_i) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (kill_i) state_d = MD_IDLE;
  end

  always_comb begin
    req_ready_o  = (state_q == MD_IDLE) && !kill_i;
    resp_valid_o = (state_q == MD_DONE);
    busy_o       = (state_q != MD_IDLE);
    result_o     = result_q;
  end

endmodule
